uart_rx_fifo_gpio: RTL and testbench
====================================

# uart_rx_fifo_gpio

Memory-mapped UART receiver peripheral for the MCU data bus; next generation of the single-byte RX GPIO. Integrates the serial receiver (oversampled mid-bit sampling, programmable divisor, optional parity), a parametrised receive FIFO, sticky error flags, and a level interrupt. Occupies the RXDATA (0x5xxx_xxxx), RXCTRL (0x6xxx_xxxx) and RXSTATUS (0x7xxx_xxxx) windows, decoded on addr[31:28].

## Interface
- DATA_BITS, 8: frame data bits, 5..8.
- FIFO_DEPTH, 16: entries, power of two, 2..256.
- DEFAULT_DIV, 434: reset value of the baud divisor, clocks per bit.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- addr  in  32  bus address; window selected by addr[31:28].
- data_in  in  32  bus write data.
- rd_strobe  in  1  read request, one cycle.
- wr_strobe  in  4  byte write enables; any bit set = write.
- data_out  out  32  registered read data.
- uart_rx  in  1  asynchronous serial input, idle high.
- irq  out  1  registered interrupt, active high.

## Operation
- uart_rx passes through a 2-flop synchroniser (reset to 1) before use.
- CTRL (0x6): [0] rx_en, [1] parity_en, [2] parity_odd, [3] irq_en, [4] flush (write-1, self-clearing, reads 0), [31:16] divisor. Reset value {DEFAULT_DIV, 16'h0001}. Divisor < 4 is treated as 4.
- Receiver FSM: IDLE, START, DATA, PARITY, STOP.
  - IDLE: synced rx == 0 and rx_en -> START, bit counter = divisor/2 (floor).
  - START: at count expiry re-sample; 0 -> DATA (counter = divisor), 1 -> IDLE (glitch, no flag).
  - DATA: sample every divisor clocks, LSB first, DATA_BITS samples; then PARITY if parity_en, else STOP.
  - PARITY: one sample; error if XOR(data, sample) != parity_odd.
  - STOP: one sample, then IDLE immediately (next start can be detected in the second half of the stop bit).
- Frame outcome at stop sample: stop = 0 -> framing error sticky set, frame discarded. Stop = 1 -> push into FIFO; parity error sets sticky bit but the frame is still pushed. Push while full (and no simultaneous pop) -> frame dropped, overrun sticky set.
- rx_en cleared mid-frame: FSM forced to IDLE next cycle, partial frame discarded, no flags.
- STATUS (0x7) read: [0] not_empty, [1] full, [2] overrun, [3] framing_err, [4] parity_err, [15:8] count (0..FIFO_DEPTH; saturates at 255 for 256-deep). Write: bits [4:2] are write-1-to-clear; other bits ignored.
- RXDATA (0x5) read: non-empty -> data_out = {1'b1, 23'b0, head zero-extended to 8 bits}, head popped. Empty -> data_out = 0, no pointer change. Writes ignored.
- Simultaneous push and pop: both occur; count unchanged; allowed even when full (pop frees the slot).
- Flush: pointers and count to 0 next cycle; a push in the same cycle is discarded; sticky flags unaffected.
- Reads of an address outside the three windows leave data_out unchanged.
- irq = irq_en & (not_empty | overrun | framing_err | parity_err), registered.

## Timing
- Reset (rst_n low at a clk edge): data_out = 0, irq = 0, FSM IDLE, FIFO empty, sticky flags 0, CTRL = reset value, synchroniser = 1.
- Read latency: data_out valid the cycle after rd_strobe; holds until the next decoded read.
- Pop takes effect the cycle after rd_strobe; a back-to-back read returns the next entry.
- Push: FIFO/count/status updated the cycle after the stop-bit sample; irq asserts one cycle after that.
- Start-edge to push: 2 (sync) + floor(div/2) + (DATA_BITS + parity_en + 1) * div + 1 clocks, +/-1.
- CTRL write takes effect the next cycle; divisor change mid-frame applies from the next bit reload.
- Sticky clear and a same-cycle set: set wins.

## Test plan
- DEFAULT_DIV=16, frame 0xA5 8N1 -> STATUS reads 0x0000_0101; RXDATA read returns 0x8000_00A5; STATUS then 0x0000_0000.
- Send FIFO_DEPTH+1 frames 0x00..0x10 without reading -> STATUS full=1, overrun=1, count=16; 16 reads return 0x00..0x0F in order; 0x10 absent; write 0x4 to STATUS clears overrun.
- parity_en=1, parity_odd=0, frame 0x03 with parity bit 1 -> parity_err=1, data 0x03 readable; frame with stop bit 0 -> framing_err=1, count unchanged.
- 1-clock low glitch shorter than div/2 on uart_rx -> no push, no flags, FSM back to IDLE.
- FIFO full, stop-bit sample in same cycle as RXDATA read -> read returns oldest entry, new frame stored, count stays 16, no overrun.
- irq_en=1, one frame received -> irq=1; flush via CTRL write 0x0010_0019 -> count 0, irq=0; rst_n low mid-frame -> all outputs 0, CTRL reset.

Source files
------------

// File: rtl/uart_rx_fifo_gpio.sv
// UART receive peripheral: synchronised serial input, oversampling receiver FSM,
// receive FIFO, sticky error flags and a level interrupt on a 32-bit MCU bus.
module uart_rx_fifo_gpio #(
   parameter int DATA_BITS   = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic        rd_strobe,
   input  logic [3:0]  wr_strobe,
   output logic [31:0] data_out,
   input  logic        uart_rx,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   function automatic logic [7:0] sat_count(input logic [CW-1:0] c);
      if (int'(c) > 255) return 8'hFF;
      else               return 8'(c);
   endfunction

   // synchroniser
   logic rx_s1_q, rx_s2_q;

   // control register
   logic        rx_en_q,   rx_en_d;
   logic        par_en_q,  par_en_d;
   logic        par_odd_q, par_odd_d;
   logic        irq_en_q,  irq_en_d;
   logic [15:0] div_q,     div_d;

   // receiver
   state_t                 state_q, state_d;
   logic [15:0]            cnt_q,   cnt_d;
   logic [3:0]             bit_q,   bit_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   par_bad_q, par_bad_d;
   logic                   push, frame_err;

   // fifo and status
   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q,  count_d;
   logic                   ovr_q, ovr_d;
   logic                   fe_q,  fe_d;
   logic                   pe_q,  pe_d;
   logic [31:0]            data_out_q, data_out_d;
   logic                   irq_q, irq_d;

   logic        sel_data, sel_ctrl, sel_stat;
   logic        wr_any, ctrl_wr, stat_wr, flush;
   logic        full, empty, pop, push_ok, ovr_set;
   logic [15:0] div_eff;
   logic        tick;
   logic [31:0] ctrl_word, stat_word;
   logic        unused_bits;

   assign unused_bits = ^{addr[27:0], data_in[15:5]};

   assign sel_data = (addr[31:28] == 4'h5);
   assign sel_ctrl = (addr[31:28] == 4'h6);
   assign sel_stat = (addr[31:28] == 4'h7);
   assign wr_any   = |wr_strobe;
   assign ctrl_wr  = wr_any & sel_ctrl;
   assign stat_wr  = wr_any & sel_stat;
   assign flush    = ctrl_wr & data_in[4];

   assign div_eff  = (div_q < 16'd4) ? 16'd4 : div_q;
   assign tick     = (cnt_q <= 16'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
      end else begin
         rx_s1_q <= uart_rx;
         rx_s2_q <= rx_s1_q;
      end
   end

   always_comb begin
      rx_en_d   = rx_en_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      irq_en_d  = irq_en_q;
      div_d     = div_q;
      if (ctrl_wr) begin
         rx_en_d   = data_in[0];
         par_en_d  = data_in[1];
         par_odd_d = data_in[2];
         irq_en_d  = data_in[3];
         div_d     = data_in[31:16];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_en_q   <= 1'b1;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         irq_en_q  <= 1'b0;
         div_q     <= 16'(DEFAULT_DIV);
      end else begin
         rx_en_q   <= rx_en_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         irq_en_q  <= irq_en_d;
         div_q     <= div_d;
      end
   end

   // Counter loads with N and samples on the cycle it reads 1, i.e. N clocks later.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      par_bad_d = par_bad_q;
      push      = 1'b0;
      frame_err = 1'b0;
      if (!rx_en_q) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s2_q) begin
                  state_d   = S_START;
                  cnt_d     = div_eff >> 1;
                  par_bad_d = 1'b0;
               end
            end
            S_START: begin
               if (tick) begin
                  if (!rx_s2_q) begin
                     state_d = S_DATA;
                     cnt_d   = div_eff;
                     bit_d   = 4'd0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            S_DATA: begin
               if (tick) begin
                  shreg_d = {rx_s2_q, shreg_q[DATA_BITS-1:1]};
                  cnt_d   = div_eff;
                  bit_d   = bit_q + 4'd1;
                  if (bit_q == 4'(DATA_BITS - 1))
                     state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            S_PARITY: begin
               if (tick) begin
                  par_bad_d = ((^shreg_q) ^ rx_s2_q) != par_odd_q;
                  cnt_d     = div_eff;
                  state_d   = S_STOP;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            S_STOP: begin
               if (tick) begin
                  state_d = S_IDLE;
                  if (rx_s2_q) push = 1'b1;
                  else         frame_err = 1'b1;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         bit_q     <= 4'd0;
         shreg_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         par_bad_q <= par_bad_d;
      end
   end

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign pop     = rd_strobe & sel_data & ~empty;
   assign push_ok = push & ~flush & (~full | pop);
   assign ovr_set = push & ~flush & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_ok && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push_ok) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
   end

   always_comb begin
      ovr_d = (ovr_q & ~(stat_wr & data_in[2])) | ovr_set;
      fe_d  = (fe_q  & ~(stat_wr & data_in[3])) | frame_err;
      pe_d  = (pe_q  & ~(stat_wr & data_in[4])) | (push & par_bad_q);
   end

   assign ctrl_word = {div_q, 11'h0, 1'b0, irq_en_q, par_odd_q, par_en_q, rx_en_q};
   assign stat_word = {16'h0, sat_count(count_q), 3'b0, pe_q, fe_q, ovr_q, full, ~empty};

   always_comb begin
      data_out_d = data_out_q;
      if (rd_strobe) begin
         if (sel_data)
            data_out_d = empty ? 32'h0 : {1'b1, 23'h0, 8'(mem_q[rd_ptr_q])};
         else if (sel_ctrl)
            data_out_d = ctrl_word;
         else if (sel_stat)
            data_out_d = stat_word;
      end
      irq_d = irq_en_q & (~empty | ovr_q | fe_q | pe_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovr_q      <= 1'b0;
         fe_q       <= 1'b0;
         pe_q       <= 1'b0;
         data_out_q <= 32'h0;
         irq_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovr_q      <= ovr_d;
         fe_q       <= fe_d;
         pe_q       <= pe_d;
         data_out_q <= data_out_d;
         irq_q      <= irq_d;
      end
   end

   assign data_out = data_out_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_gpio.sv
// Directed bench for uart_rx_fifo_gpio with a 16-clock bit period and a 16-entry FIFO.
module tb_uart_rx_fifo_gpio;

   localparam logic [31:0] A_DATA = 32'h5000_0000;
   localparam logic [31:0] A_CTRL = 32'h6000_0000;
   localparam logic [31:0] A_STAT = 32'h7000_0000;
   localparam int          BIT_T  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] data_in = 32'h0;
   logic        rd_strobe = 1'b0;
   logic [3:0]  wr_strobe = 4'h0;
   logic [31:0] data_out;
   logic        uart_rx = 1'b1;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rd;

   uart_rx_fifo_gpio #(
      .DATA_BITS  (8),
      .FIFO_DEPTH (16),
      .DEFAULT_DIV(16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .data_in  (data_in),
      .rd_strobe(rd_strobe),
      .wr_strobe(wr_strobe),
      .data_out (data_out),
      .uart_rx  (uart_rx),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // All bus and line activity is launched from a falling edge.
   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr      = a;
      rd_strobe = 1'b1;
      @(negedge clk);
      rd_strobe = 1'b0;
      d         = data_out;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr      = a;
      data_in   = d;
      wr_strobe = 4'hF;
      @(negedge clk);
      wr_strobe = 4'h0;
   endtask

   task automatic send_bit(input logic v);
      uart_rx = v;
      repeat (BIT_T) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par,
                             input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (use_par) send_bit(par);
      send_bit(stop);
      uart_rx = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_data_out", data_out, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      bus_read(A_STAT, rd); check("reset_status", rd, 32'h0);
      bus_read(A_CTRL, rd); check("reset_ctrl", rd, 32'h0010_0001);

      // 8N1 frame 0xA5
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      bus_read(A_STAT, rd); check("a5_status", rd, 32'h0000_0101);
      bus_read(A_DATA, rd); check("a5_data", rd, 32'h8000_00A5);
      bus_read(A_STAT, rd); check("a5_status_after", rd, 32'h0);
      bus_read(A_DATA, rd); check("empty_read", rd, 32'h0);

      // one-clock glitch, then a normal frame
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      bus_read(A_STAT, rd); check("glitch_status", rd, 32'h0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      bus_read(A_STAT, rd); check("post_glitch_status", rd, 32'h0000_0101);
      bus_read(A_DATA, rd); check("post_glitch_data", rd, 32'h8000_003C);

      // overflow: 17 frames into 16 slots
      for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      bus_read(A_STAT, rd); check("ovf_status", rd, 32'h0000_1007);
      for (int i = 0; i < 16; i++) begin
         bus_read(A_DATA, rd);
         check($sformatf("ovf_data%0d", i), rd, 32'h8000_0000 | 32'(i));
      end
      bus_read(A_DATA, rd); check("ovf_drained", rd, 32'h0);
      bus_read(A_STAT, rd); check("ovf_sticky", rd, 32'h0000_0004);
      bus_write(A_STAT, 32'h4);
      bus_read(A_STAT, rd); check("ovf_cleared", rd, 32'h0);

      // full FIFO, read in the same cycle as the stop-bit sample
      for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      bus_read(A_STAT, rd); check("full_status", rd, 32'h0000_1003);
      fork
         send_frame(8'h30, 1'b0, 1'b0, 1'b1);
         begin
            repeat (154) @(negedge clk);
            bus_read(A_DATA, rd); check("simul_data", rd, 32'h8000_0020);
         end
      join
      repeat (4) @(negedge clk);
      bus_read(A_STAT, rd); check("simul_status", rd, 32'h0000_1003);
      for (int i = 0; i < 16; i++) begin
         bus_read(A_DATA, rd);
         check($sformatf("simul_drain%0d", i), rd, 32'h8000_0021 + 32'(i));
      end

      // even parity: 0x03 with parity bit 1 is wrong; then a framing error
      bus_write(A_CTRL, 32'h0010_0003);
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      bus_read(A_STAT, rd); check("par_status", rd, 32'h0000_0111);
      bus_read(A_DATA, rd); check("par_data", rd, 32'h8000_0003);
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      bus_read(A_STAT, rd); check("frm_status", rd, 32'h0000_0018);
      bus_write(A_STAT, 32'h1C);
      bus_read(A_STAT, rd); check("err_cleared", rd, 32'h0);

      // interrupt and flush
      bus_write(A_CTRL, 32'h0010_0009);
      repeat (2) @(negedge clk);
      check("irq_idle", {31'h0, irq}, 32'h0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("irq_frame", {31'h0, irq}, 32'h1);
      bus_write(A_CTRL, 32'h0010_0019);
      repeat (3) @(negedge clk);
      bus_read(A_STAT, rd); check("flush_status", rd, 32'h0);
      check("flush_irq", {31'h0, irq}, 32'h0);
      bus_read(A_CTRL, rd); check("flush_ctrl", rd, 32'h0010_0009);
      send_frame(8'h77, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("irq_frame2", {31'h0, irq}, 32'h1);
      bus_read(A_CTRL, rd); check("pre_reset_ctrl", rd, 32'h0010_0009);

      // reset in the middle of a frame
      fork
         send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
         begin
            repeat (60) @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            check("midreset_data_out", data_out, 32'h0);
            check("midreset_irq", {31'h0, irq}, 32'h0);
            rst_n = 1'b1;
         end
      join
      repeat (20) @(negedge clk);
      bus_read(A_CTRL, rd); check("post_reset_ctrl", rd, 32'h0010_0001);
      bus_read(A_STAT, rd); check("post_reset_status", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
